wb_commit_queue: RTL

Parametrised in-order writeback stage for the rv32i pipeline. It sits between the memory stage and the register file, buffering up to DEPTH completed or load-pending instructions. It accepts load data returning from the data memory after the memory stage has advanced, then aligns and extends it and retires one instruction per cycle to the register file. It also provides forwarding/hazard lookups over all buffered results and counts retired instructions.

---
 rtl/wb_commit_queue_pkg.sv | 25 ++
 rtl/wb_commit_queue_load_align.sv | 37 +++
 rtl/wb_commit_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_queue_pkg.sv
// Shared types for the rv32i writeback commit queue.
//   load_funct3_t : load funct3 encodings (lb/lh/lw/lbu/lhu)
//   wb_entry_t    : one buffered instruction awaiting retirement
package wb_commit_queue_pkg;

  typedef enum logic [2:0] {
    LdB  = 3'b000,
    LdH  = 3'b001,
    LdW  = 3'b010,
    LdBu = 3'b100,
    LdHu = 3'b101
  } load_funct3_t;

  // funct3 is kept as raw bits: undefined encodings must survive to the aligner.
  typedef struct packed {
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        we;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        done;
  } wb_entry_t;

endpackage

// File: rtl/wb_commit_queue_load_align.sv
// load_align: combinational load data alignment and extension.
//   raw     : raw 32-bit word from data memory
//   funct3  : load type; undefined encodings pass the word through
//   addr_lo : byte offset within the word
//   result  : aligned, sign/zero-extended value
module load_align
  import wb_commit_queue_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
    endcase
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    case (funct3)
      LdB:     result = {{24{byte_sel[7]}}, byte_sel};
      LdH:     result = {{16{half_sel[15]}}, half_sel};
      LdBu:    result = {24'd0, byte_sel};
      LdHu:    result = {16'd0, half_sel};
      LdW:     result = raw;
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order writeback buffer between memory stage and register file.
//   in_*          : instruction from memory stage, accepted on in_valid && in_ready
//   dmem_*        : load responses, returned in load issue order
//   rd_s/rd_v/wr_en : registered register-file write port
//   fwd_*         : combinational forwarding/hazard lookup, one set per query port
//   retire_count  : instructions retired since reset (wraps)
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd_s,
  input  logic [31:0]              in_rd_v,
  input  logic                     in_regf_we,
  input  logic                     in_is_load,
  input  logic [2:0]               in_funct3,
  input  logic [1:0]               in_addr_lo,
  input  logic                     dmem_resp,
  input  logic [31:0]              dmem_rdata,
  output logic [4:0]               rd_s,
  output logic [31:0]              rd_v,
  output logic                     wr_en,
  input  logic [NUM_FWD-1:0][4:0]  fwd_s,
  output logic [NUM_FWD-1:0]       fwd_hit,
  output logic [NUM_FWD-1:0]       fwd_pending,
  output logic [NUM_FWD-1:0][31:0] fwd_v,
  output logic [CNT_W-1:0]         retire_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  typedef logic [PtrW:0] ptr_t;

  wb_entry_t mem_q [DEPTH];
  ptr_t      head_q, tail_q, ld_q;
  ptr_t      tail_d, ld_d, ld_fallback;
  ptr_t      count, span, cand, nxt_ld;
  logic      nxt_found;

  logic [PtrW-1:0] head_idx, tail_idx, ld_idx;
  logic [PtrW-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] slot_valid;

  wb_entry_t   head_ent, ld_ent;
  logic        do_push, do_pop, do_resolve, ld_any;
  logic [31:0] ld_data;
  logic [NUM_FWD-1:0] buf_hit;

  assign head_idx = head_q[PtrW-1:0];
  assign tail_idx = tail_q[PtrW-1:0];
  assign ld_idx   = ld_q[PtrW-1:0];
  assign count    = tail_q - head_q;
  assign in_ready = (count != ptr_t'(DEPTH));

  assign head_ent = mem_q[head_idx];
  assign ld_ent   = mem_q[ld_idx];

  // ld_q parks at tail_q whenever no unresolved load is buffered.
  assign ld_any     = (ld_q != tail_q);
  assign do_push    = in_valid && in_ready;
  assign do_pop     = (count != '0) && head_ent.done;
  assign do_resolve = dmem_resp && ld_any;
  assign tail_d     = do_push ? tail_q + ptr_t'(1) : tail_q;

  load_align u_align (
    .raw     (dmem_rdata),
    .funct3  (ld_ent.funct3),
    .addr_lo (ld_ent.addr_lo),
    .result  (ld_data)
  );

  // Slot k is the k-th oldest buffered entry.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot_idx[k]   = head_idx + PtrW'(k);
      slot_valid[k] = ptr_t'(k) < count;
    end
  end

  // Responses arrive in order, so every load younger than ld_q is still unresolved;
  // the next target is simply the next load entry before the tail.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ld    = tail_q;
    cand      = '0;
    span      = tail_q - ld_q;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      cand = ld_q + ptr_t'(k);
      if (!nxt_found && (ptr_t'(k) < span) && mem_q[cand[PtrW-1:0]].is_load) begin
        nxt_found = 1'b1;
        nxt_ld    = cand;
      end
    end
  end

  always_comb begin
    // A load enqueued now lands at tail_q; anything else keeps ld_q parked at the tail.
    ld_fallback = (do_push && in_is_load) ? tail_q : tail_d;
    if (do_resolve) begin
      ld_d = nxt_found ? nxt_ld : ld_fallback;
    end else if (!ld_any) begin
      ld_d = ld_fallback;
    end else begin
      ld_d = ld_q;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_idx] <= '{rd_s:    in_rd_s,
                           rd_v:    in_is_load ? 32'd0 : in_rd_v,
                           we:      in_regf_we,
                           is_load: in_is_load,
                           funct3:  in_funct3,
                           addr_lo: in_addr_lo,
                           done:    !in_is_load};
    end
    if (do_resolve) begin
      mem_q[ld_idx].rd_v <= ld_data;
      mem_q[ld_idx].done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      ld_q         <= '0;
      wr_en        <= 1'b0;
      rd_s         <= '0;
      rd_v         <= '0;
      retire_count <= '0;
    end else begin
      tail_q <= tail_d;
      ld_q   <= ld_d;
      if (do_pop) begin
        head_q       <= head_q + ptr_t'(1);
        wr_en        <= head_ent.we && (head_ent.rd_s != 5'd0);
        rd_s         <= head_ent.rd_s;
        rd_v         <= head_ent.rd_v;
        retire_count <= retire_count + CNT_W'(1);
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    for (int unsigned p = 0; p < NUM_FWD; p++) begin
      buf_hit[p]     = 1'b0;
      fwd_pending[p] = 1'b0;
      fwd_v[p]       = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (slot_valid[k] && mem_q[slot_idx[k]].we &&
            (mem_q[slot_idx[k]].rd_s == fwd_s[p])) begin
          buf_hit[p]     = 1'b1;
          fwd_v[p]       = mem_q[slot_idx[k]].rd_v;
          fwd_pending[p] = mem_q[slot_idx[k]].is_load && !mem_q[slot_idx[k]].done;
        end
      end
      fwd_hit[p] = buf_hit[p];
      if (!buf_hit[p] && wr_en && (rd_s == fwd_s[p])) begin
        fwd_hit[p] = 1'b1;
        fwd_v[p]   = rd_v;
      end
      if (fwd_s[p] == 5'd0) begin
        fwd_hit[p]     = 1'b0;
        fwd_pending[p] = 1'b0;
      end
    end
  end

endmodule
